// File: rtl/train_seq_ctrl.sv
// Sequencer for a loadable external state counter driving a train: issues registered ld/en strobes,
// waits one settle cycle after each, then checks that the counter actually reached the intended state.
module train_seq_ctrl #(
  parameter int unsigned ACCEL_CYCLES = 8,
  parameter int unsigned BRAKE_CYCLES = 8,
  parameter int unsigned DWELL_CYCLES = 16,
  parameter int unsigned DOOR_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       station_sensor,
  input  logic       door_closed,
  input  logic       service_end,
  input  logic       estop,
  input  logic [3:0] present_state,
  output logic       ld,
  output logic       en,
  output logic [3:0] next_state,
  output logic       motor_en,
  output logic       brake,
  output logic       door_open,
  output logic       fault
);
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ACCEL  = 4'd1,
    ST_CRUISE = 4'd2,
    ST_BRAKE  = 4'd3,
    ST_DWELL  = 4'd4,
    ST_CLOSE  = 4'd5,
    ST_DEPART = 4'd6,
    ST_ESTOP  = 4'd8,
    ST_FAULT  = 4'd9
  } state_e;

  localparam logic [15:0] ACCEL_LAST = 16'(ACCEL_CYCLES - 1);
  localparam logic [15:0] BRAKE_LAST = 16'(BRAKE_CYCLES - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
  localparam logic [15:0] DOOR_LAST  = 16'(DOOR_TIMEOUT - 1);

  logic        r_ld;
  logic        r_en;
  logic [3:0]  r_next_state;
  logic        r_pending;
  logic        r_verify;
  logic [3:0]  r_target;
  logic [15:0] r_timer;

  logic        w_cmd_ld;
  logic        w_cmd_en;
  state_e      w_cmd_val;
  logic        w_issue;
  logic [3:0]  w_target;
  logic        w_estop_req;
  logic        w_moving;

  // The emergency load is suppressed only while its own ld 8 strobe is still on the wire,
  // so a held estop produces one pulse rather than a train of them.
  always_comb begin
    w_cmd_ld    = 1'b0;
    w_cmd_en    = 1'b0;
    w_cmd_val   = ST_IDLE;
    w_estop_req = estop && (present_state != ST_ESTOP) && (present_state != ST_FAULT)
                  && !(r_ld && (r_next_state == ST_ESTOP));
    if (w_estop_req) begin
      w_cmd_ld  = 1'b1;
      w_cmd_val = ST_ESTOP;
    end else if (!r_pending) begin
      if (r_verify && (present_state != r_target)) begin
        w_cmd_ld  = 1'b1;
        w_cmd_val = ST_FAULT;
      end else begin
        case (present_state)
          ST_IDLE:   w_cmd_en = start;
          ST_ACCEL:  w_cmd_en = (r_timer == ACCEL_LAST);
          ST_CRUISE: w_cmd_en = station_sensor;
          ST_BRAKE:  w_cmd_en = (r_timer == BRAKE_LAST);
          ST_DWELL:  w_cmd_en = (r_timer == DWELL_LAST);
          ST_CLOSE: begin
            if (door_closed) begin
              w_cmd_en = 1'b1;
            end else if (r_timer == DOOR_LAST) begin
              w_cmd_ld  = 1'b1;
              w_cmd_val = ST_FAULT;
            end
          end
          ST_DEPART: begin
            w_cmd_ld  = 1'b1;
            w_cmd_val = service_end ? ST_IDLE : ST_ACCEL;
          end
          ST_ESTOP: begin
            if (!estop && start) begin
              w_cmd_ld  = 1'b1;
              w_cmd_val = ST_IDLE;
            end
          end
          ST_FAULT: ;
          default: begin
            w_cmd_ld  = 1'b1;
            w_cmd_val = ST_FAULT;
          end
        endcase
      end
    end
    w_issue  = w_cmd_ld | w_cmd_en;
    w_target = w_cmd_ld ? w_cmd_val : (present_state + 4'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld         <= 1'b1;
      r_en         <= 1'b0;
      r_next_state <= ST_IDLE;
      r_pending    <= 1'b1;
      r_verify     <= 1'b0;
      r_target     <= ST_IDLE;
      r_timer      <= '0;
    end else begin
      r_ld         <= w_cmd_ld;
      r_en         <= w_cmd_en;
      r_next_state <= w_cmd_val;
      r_pending    <= w_issue;
      r_verify     <= r_pending;
      if (w_issue) begin
        r_target <= w_target;
        r_timer  <= '0;
      end else if (!r_pending && (r_timer != 16'hFFFF)) begin
        r_timer <= r_timer + 16'd1;
      end
    end
  end

  assign ld         = r_ld;
  assign en         = r_en;
  assign next_state = r_next_state;

  // Everything that is not a moving state (including illegal codes) keeps the brake on.
  assign w_moving  = (present_state == ST_ACCEL) || (present_state == ST_CRUISE)
                     || (present_state == ST_DEPART);
  assign motor_en  = w_moving && !estop;
  assign brake     = estop || !w_moving;
  assign door_open = (present_state == ST_DWELL) && !estop;
  assign fault     = (present_state == ST_FAULT);
endmodule

// File: tb/tb_train_seq_ctrl.sv
// Bench for train_seq_ctrl: models the loadable counter, drives randomized journeys and fault cases,
// and predicts strobe timing from the dwell/event rules of each state.
module tb_train_seq_ctrl;
  localparam int A = 4;
  localparam int B = 4;
  localparam int D = 8;
  localparam int T = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       station_sensor = 1'b0;
  logic       door_closed = 1'b0;
  logic       service_end = 1'b0;
  logic       estop = 1'b0;
  logic [3:0] cnt = 4'd11;
  logic       ld, en, motor_en, brake, door_open, fault;
  logic [3:0] next_state;
  bit         hold_cnt = 1'b0;
  bit         force_on = 1'b0;
  logic [3:0] force_val = 4'd0;
  int         total = 0;
  int         bad = 0;

  train_seq_ctrl #(
    .ACCEL_CYCLES(A),
    .BRAKE_CYCLES(B),
    .DWELL_CYCLES(D),
    .DOOR_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .station_sensor(station_sensor),
    .door_closed(door_closed),
    .service_end(service_end),
    .estop(estop),
    .present_state(cnt),
    .ld(ld),
    .en(en),
    .next_state(next_state),
    .motor_en(motor_en),
    .brake(brake),
    .door_open(door_open),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // External loadable counter; hold_cnt models a stuck counter, force_on injects arbitrary codes.
  always @(posedge clk) begin
    if (force_on) cnt <= force_val;
    else if (!hold_cnt) begin
      if (ld) cnt <= next_state;
      else if (en) cnt <= cnt + 4'd1;
    end
  end

  always @(negedge clk) begin
    total++;
    if (ld === 1'b1 && en === 1'b1) begin
      bad++;
      $display("FAIL ld_en_overlap: got ld=%b en=%b, want never both high", ld, en);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // A state becomes visible the cycle after its strobe; a timed state of length n then
  // shows its leaving strobe n cycles later, i.e. n+1 cycles after the entering strobe.
  function automatic int timed_gap(input int n);
    return n + 1;
  endfunction

  function automatic logic [3:0] decode_ref(input logic [3:0] s, input logic e);
    logic moving;
    moving = (s == 4'd1) || (s == 4'd2) || (s == 4'd6);
    return {moving && !e, e || !moving, (s == 4'd4) && !e, s == 4'd9};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the next strobe; gap = cycles waited, -1 if the budget ran out.
  task automatic wait_cmd(input int budget, output int gap, output logic [5:0] cmd);
    gap = -1;
    cmd = '0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (ld || en) begin
        gap = i;
        cmd = {ld, en, next_state};
        return;
      end
    end
  endtask

  task automatic quiet(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ld || en) seen++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {start, station_sensor, door_closed, service_end, estop} = '0;
    hold_cnt = 1'b0;
    force_on = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic goto_close(output bit ok);
    int g;
    logic [5:0] c;
    ok = 1'b1;
    start = 1'b1;
    wait_cmd(4, g, c); ok = ok && (g > 0);
    start = 1'b0;
    wait_cmd(A + 6, g, c); ok = ok && (g > 0);
    station_sensor = 1'b1;
    wait_cmd(4, g, c); ok = ok && (g > 0);
    station_sensor = 1'b0;
    wait_cmd(B + 6, g, c); ok = ok && (g > 0);
    wait_cmd(D + 6, g, c); ok = ok && (g > 0);
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    repeat (3) tick();
    total++; if (ld !== 1'b1) begin bad++; $display("FAIL rst_ld: got=%b want=1", ld); end
    total++; if (en !== 1'b0) begin bad++; $display("FAIL rst_en: got=%b want=0", en); end
    total++; if (next_state !== 4'd0) begin bad++; $display("FAIL rst_next: got=%0d want=0", next_state); end
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL rst_state: got=%0d want=0", cnt); end
    total++; if ({motor_en, brake, fault} !== 3'b010) begin bad++; $display("FAIL rst_outputs: got=%b want=010", {motor_en, brake, fault}); end
    rst = 1'b0;
    quiet(4, seen);
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_quiet: got=%0d cmds want=0", seen); end
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL rst_idle: got=%0d want=0", cnt); end
  endtask

  task automatic test_journey(input int legs);
    int g, d, seen, dcount;
    logic [5:0] c;
    bit in_accel, se;
    in_accel = 1'b0;
    for (int leg = 0; leg < legs; leg++) begin
      if (!in_accel) begin
        start = 1'b1;
        wait_cmd(4, g, c);
        total++; if (g !== 1 || c[5:4] !== 2'b01) begin bad++; $display("FAIL idle_start: got gap=%0d cmd=%b want gap=1 en", g, c); end
        start = 1'b0;
      end
      wait_cmd(A + 6, g, c);
      total++; if (g !== timed_gap(A) || c[5:4] !== 2'b01) begin bad++; $display("FAIL accel_done: got gap=%0d cmd=%b want gap=%0d en", g, c, timed_gap(A)); end
      tick();
      total++; if ({cnt, motor_en, brake} !== {4'd2, 1'b1, 1'b0}) begin bad++; $display("FAIL cruise: got state=%0d motor=%b brake=%b want 2/1/0", cnt, motor_en, brake); end
      d = $urandom_range(0, 5);
      quiet(d, seen);
      total++; if (seen !== 0) begin bad++; $display("FAIL cruise_hold: got=%0d cmds want=0", seen); end
      station_sensor = 1'b1;
      wait_cmd(3, g, c);
      total++; if (g !== 1 || c[5:4] !== 2'b01) begin bad++; $display("FAIL station: got gap=%0d cmd=%b want gap=1 en", g, c); end
      station_sensor = 1'b0;
      wait_cmd(B + 6, g, c);
      total++; if (g !== timed_gap(B) || c[5:4] !== 2'b01) begin bad++; $display("FAIL brake_done: got gap=%0d cmd=%b want gap=%0d en", g, c, timed_gap(B)); end
      dcount = 0;
      g = -1;
      for (int i = 1; i <= D + 6; i++) begin
        tick();
        if (ld || en) begin
          g = i;
          c = {ld, en, next_state};
          break;
        end
        if (door_open) dcount++;
      end
      total++; if (g !== timed_gap(D) || c[5:4] !== 2'b01) begin bad++; $display("FAIL dwell_done: got gap=%0d cmd=%b want gap=%0d en", g, c, timed_gap(D)); end
      total++; if (dcount !== D) begin bad++; $display("FAIL door_open_len: got=%0d want=%0d", dcount, D); end
      tick();
      total++; if (cnt !== 4'd5 || door_open !== 1'b0) begin bad++; $display("FAIL close_entry: got state=%0d door=%b want 5/0", cnt, door_open); end
      d = $urandom_range(0, 5);
      quiet(d, seen);
      total++; if (seen !== 0) begin bad++; $display("FAIL close_hold: got=%0d cmds want=0", seen); end
      door_closed = 1'b1;
      wait_cmd(3, g, c);
      total++; if (g !== 1 || c[5:4] !== 2'b01) begin bad++; $display("FAIL doors_shut: got gap=%0d cmd=%b want gap=1 en", g, c); end
      door_closed = 1'b0;
      se = (leg == legs - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      service_end = se;
      wait_cmd(4, g, c);
      total++; if (g !== 2 || c !== {2'b10, (se ? 4'd0 : 4'd1)}) begin bad++; $display("FAIL depart: got gap=%0d cmd=%b want gap=2 ld %0d", g, c, se ? 0 : 1); end
      service_end = 1'b0;
      if (se) begin
        tick();
        in_accel = 1'b0;
      end else begin
        in_accel = 1'b1;
      end
    end
  endtask

  task automatic test_estop();
    int g, d, seen;
    logic [5:0] c;
    start = 1'b1;
    wait_cmd(4, g, c);
    start = 1'b0;
    wait_cmd(A + 6, g, c);
    tick();
    d = $urandom_range(0, 4);
    quiet(d, seen);
    estop = 1'b1;
    #1;
    total++; if (motor_en !== 1'b0 || brake !== 1'b1) begin bad++; $display("FAIL estop_decode: got motor=%b brake=%b want 0/1", motor_en, brake); end
    wait_cmd(3, g, c);
    total++; if (g !== 1 || c !== 6'b10_1000) begin bad++; $display("FAIL estop_ld: got gap=%0d cmd=%b want gap=1 ld 8", g, c); end
    quiet(1, seen);
    total++; if (seen !== 0 || cnt !== 4'd8) begin bad++; $display("FAIL estop_state: got cmds=%0d state=%0d want 0/8", seen, cnt); end
    estop = 1'b0;
    start = 1'b1;
    wait_cmd(3, g, c);
    total++; if (g !== 1 || c !== 6'b10_0000) begin bad++; $display("FAIL estop_recover: got gap=%0d cmd=%b want gap=1 ld 0", g, c); end
    start = 1'b0;
    tick();
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL estop_idle: got=%0d want=0", cnt); end
  endtask

  task automatic test_mismatch();
    int g;
    logic [5:0] c;
    hold_cnt = 1'b1;
    start = 1'b1;
    wait_cmd(3, g, c);
    start = 1'b0;
    total++; if (g !== 1 || c[5:4] !== 2'b01) begin bad++; $display("FAIL stuck_en: got gap=%0d cmd=%b want gap=1 en", g, c); end
    wait_cmd(4, g, c);
    total++; if (g !== 2 || c !== 6'b10_1001) begin bad++; $display("FAIL stuck_fault: got gap=%0d cmd=%b want gap=2 ld 9", g, c); end
    hold_cnt = 1'b0;
    tick();
    total++; if (cnt !== 4'd9 || fault !== 1'b1) begin bad++; $display("FAIL stuck_state: got state=%0d fault=%b want 9/1", cnt, fault); end
  endtask

  task automatic test_illegal();
    int g, r;
    logic [5:0] c;
    r = $urandom_range(0, 6);
    force_val = (r == 0) ? 4'd7 : 4'(9 + r);
    force_on = 1'b1;
    wait_cmd(4, g, c);
    force_on = 1'b0;
    total++; if (g !== 2 || c !== 6'b10_1001) begin bad++; $display("FAIL illegal_%0d: got gap=%0d cmd=%b want gap=2 ld 9", force_val, g, c); end
    tick();
    total++; if (cnt !== 4'd9) begin bad++; $display("FAIL illegal_state: got=%0d want=9", cnt); end
  endtask

  task automatic test_timeout();
    int g, seen;
    logic [5:0] c;
    bit ok;
    goto_close(ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout_setup: got ok=%b want 1", ok); end
    wait_cmd(T + 6, g, c);
    total++; if (g !== timed_gap(T) || c !== 6'b10_1001) begin bad++; $display("FAIL door_timeout: got gap=%0d cmd=%b want gap=%0d ld 9", g, c, timed_gap(T)); end
    tick();
    total++; if ({cnt, fault, brake} !== {4'd9, 1'b1, 1'b1}) begin bad++; $display("FAIL fault_state: got state=%0d fault=%b brake=%b want 9/1/1", cnt, fault, brake); end
    start = 1'b1;
    quiet(6, seen);
    total++; if (seen !== 0) begin bad++; $display("FAIL fault_sticky_cmds: got=%0d want=0", seen); end
    total++; if (fault !== 1'b1 || brake !== 1'b1) begin bad++; $display("FAIL fault_sticky: got fault=%b brake=%b want 1/1", fault, brake); end
    start = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    quiet(2, seen);
    total++; if (seen !== 0 || cnt !== 4'd0 || fault !== 1'b0) begin bad++; $display("FAIL fault_reset: got cmds=%0d state=%0d fault=%b want 0/0/0", seen, cnt, fault); end
  endtask

  task automatic test_estop_wins();
    int g, seen;
    logic [5:0] c;
    bit ok;
    goto_close(ok);
    quiet(T, seen);
    total++; if (!ok || seen !== 0) begin bad++; $display("FAIL ewins_setup: got ok=%b cmds=%0d want 1/0", ok, seen); end
    estop = 1'b1;
    door_closed = 1'b1;
    wait_cmd(3, g, c);
    total++; if (g !== 1 || c !== 6'b10_1000) begin bad++; $display("FAIL estop_wins: got gap=%0d cmd=%b want gap=1 ld 8", g, c); end
    estop = 1'b0;
    door_closed = 1'b0;
  endtask

  task automatic test_door_wins();
    int g, seen;
    logic [5:0] c;
    bit ok;
    goto_close(ok);
    quiet(T, seen);
    total++; if (!ok || seen !== 0) begin bad++; $display("FAIL dwins_setup: got ok=%b cmds=%0d want 1/0", ok, seen); end
    door_closed = 1'b1;
    wait_cmd(3, g, c);
    total++; if (g !== 1 || c[5:4] !== 2'b01) begin bad++; $display("FAIL door_wins: got gap=%0d cmd=%b want gap=1 en", g, c); end
    door_closed = 1'b0;
    tick();
    total++; if (cnt !== 4'd6) begin bad++; $display("FAIL door_wins_state: got=%0d want=6", cnt); end
  endtask

  task automatic test_decode();
    logic [3:0] s;
    logic       e;
    for (int i = 0; i < 24; i++) begin
      s = 4'($urandom_range(0, 15));
      e = 1'($urandom_range(0, 1));
      force_val = s;
      force_on = 1'b1;
      estop = e;
      tick();
      total++;
      if ({motor_en, brake, door_open, fault} !== decode_ref(s, e)) begin
        bad++;
        $display("FAIL decode s=%0d e=%b: got=%b want=%b", s, e, {motor_en, brake, door_open, fault}, decode_ref(s, e));
      end
    end
    force_on = 1'b0;
    estop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_journey(3);
    do_reset();
    test_estop();
    do_reset();
    test_mismatch();
    do_reset();
    test_illegal();
    do_reset();
    test_timeout();
    do_reset();
    test_estop_wins();
    do_reset();
    test_door_wins();
    do_reset();
    test_decode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/train_seq_ctrl.md
TRAIN_SEQ_CTRL -- requirements
Module: train_seq_ctrl

Interface
REQ-001 SHALL have parameters: ACCEL_CYCLES 8, cycles spent in ACCEL; BRAKE_CYCLES 8, cycles in BRAKE; DWELL_CYCLES 16, door-open time; DOOR_TIMEOUT 32, max wait for door_closed; all 1..65535.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state changes on posedge clk.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; request departure or recovery.
- station_sensor  in  1  level; train at station marker.
- door_closed  in  1  level; doors confirmed shut.
- service_end  in  1  level; return to IDLE after DEPART.
- estop  in  1  level; emergency stop.
- present_state  in  4  state value from the loadable state counter.
- ld  out  1  counter load strobe.
- en  out  1  counter increment strobe.
- next_state  out  4  counter load value.
- motor_en  out  1  traction enable.
- brake  out  1  brake applied.
- door_open  out  1  door actuator.
- fault  out  1  controller in FAULT.

Function
REQ-003 SHALL sequence an external counter that loads next_state when ld=1, increments when ld=0 and en=1, and updates one cycle after the strobe.
REQ-004 SHALL use state codes 0 IDLE, 1 ACCEL, 2 CRUISE, 3 BRAKE, 4 DWELL, 5 CLOSE, 6 DEPART, 8 ESTOP, 9 FAULT; codes 7 and 10-15 are illegal.
REQ-005 SHALL register ld, en and next_state; each command is a single-cycle pulse, and ld and en are never high together.
REQ-006 SHALL hold a pending flag for exactly one cycle after each command and issue no command while it is set.
REQ-007 SHALL compare present_state with the expected target in the cycle the pending flag clears; on mismatch it SHALL issue ld, next_state=9.
REQ-008 SHALL clear a 16-bit saturating timer on every command; the timer increments each non-pending cycle otherwise.
REQ-009 In IDLE, SHALL issue en when start=1.
REQ-010 In ACCEL, SHALL issue en when timer==ACCEL_CYCLES-1.
REQ-011 In CRUISE, SHALL issue en when station_sensor=1.
REQ-012 In BRAKE, SHALL issue en when timer==BRAKE_CYCLES-1.
REQ-013 In DWELL, SHALL issue en when timer==DWELL_CYCLES-1.
REQ-014 In CLOSE, SHALL issue en when door_closed=1; otherwise SHALL issue ld 9 when timer==DOOR_TIMEOUT-1.
REQ-015 In CLOSE, door_closed SHALL win if both conditions hold in the same cycle.
REQ-016 In DEPART, SHALL issue ld 0 if service_end=1, else ld 1.
REQ-017 In ESTOP, SHALL issue ld 0 when estop=0 and start=1.
REQ-018 FAULT SHALL be exited only by rst.
REQ-019 An illegal code SHALL cause ld 9.
REQ-020 When estop=1 and the state is not ESTOP or FAULT, SHALL issue ld 8 with priority over every other transition, including while pending.
REQ-021 SHALL decode outputs combinationally from present_state:
- motor_en=1 in ACCEL, CRUISE, DEPART, and only while estop=0.
- brake=1 in IDLE, BRAKE, DWELL, CLOSE, ESTOP, FAULT and illegal codes, or whenever estop=1.
- door_open=1 only in DWELL with estop=0.
- fault=1 only in FAULT.

Reset
REQ-022 While rst=1, SHALL drive ld=1, next_state=0, en=0, clear the timer, and set the pending flag, so the counter loads IDLE.
REQ-023 Reset asserted mid-sequence (any state, including FAULT) SHALL return to IDLE by the second cycle after rst deasserts, with no other command issued.

Verification
REQ-024 Bench parameters: ACCEL=4, BRAKE=4, DWELL=8, DOOR_TIMEOUT=10.
REQ-025 Reset, then start=1 -> en pulse, present_state 0->1, 4 cycles later 1->2, motor_en=1, brake=0.
REQ-026 In CRUISE, assert station_sensor -> 2->3->4 after 4 BRAKE cycles; door_open=1 for 8 cycles; then 5; door_closed=1 -> 6; service_end=0 -> ld 1.
REQ-027 In CLOSE, hold door_closed=0 -> ld pulse with next_state=9 on timer 9; fault=1 and brake=1 persist despite start; rst -> state 0.
REQ-028 In CRUISE, assert estop -> motor_en=0 the same cycle, ld 8 next; release estop with start=1 -> ld 0.
REQ-029 Force present_state=7, and separately hold present_state at its old value after an en -> ld 9 within 2 cycles; estop and door_closed/timeout coinciding -> estop wins.
